// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios II parallel-input port: register map,
// edge-capture selection and the warm-up state type.
package nios_system_pio_pkg;

  // Avalon word addresses of the slave registers
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Selectable edge to capture into EDGECAP
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Warm-up sequencer: edges are ignored until the synchronizer is full
  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } warm_state_t;

endpackage

// File: rtl/nios_system_pio_sync_edge.sv
// Per-bit synchronizer chain, one extra delay flop and an edge detector.
// The detected edges are forced to zero while edge_en is low so that the
// chain filling up after reset is never mistaken for an input transition.
module nios_system_pio_sync_edge
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_en,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  sync_d;
  logic [WIDTH-1:0]                  raw_edges;

  // Shift the asynchronous inputs through the chain, then delay once more
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain  <= '0;
      sync_d <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], in_port};
      sync_d <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  // Compare current and previous synchronized values for the chosen edge
  always_comb begin
    raw_edges = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: raw_edges = ~sync & sync_d;
      EDGE_ANY:     raw_edges = sync ^ sync_d;
      default:      raw_edges = sync & ~sync_d;
    endcase
  end

  assign edges = raw_edges & {WIDTH{edge_en}};

endmodule

// File: rtl/nios_system_switches_in.sv
// Avalon-MM input port: synchronized DATA, IRQMASK and write-1-to-clear
// EDGECAP registers with a level interrupt to the Nios II. Reads are
// zero-wait-state, decoded combinationally from the address.
module nios_system_switches_in
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // One count per cycle the synchronizer needs, plus the delay flop
  localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

  warm_state_t      state;
  warm_state_t      state_next;
  logic [2:0]       warm_cnt;
  logic [2:0]       warm_cnt_next;
  logic             edge_en;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  nios_system_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .edge_en (edge_en),
    .in_port (in_port),
    .sync    (sync),
    .edges   (edges)
  );

  // Warm-up state register; every reset reloads the countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WARMUP;
      warm_cnt <= WARM_LOAD;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
    end
  end

  // Count down the warm-up cycles, then stay in RUN until the next reset
  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    case (state)
      WARMUP: begin
        if (warm_cnt == 3'd1) begin
          state_next    = RUN;
          warm_cnt_next = '0;
        end else begin
          warm_cnt_next = warm_cnt - 3'd1;
        end
      end
      default: begin
        state_next    = RUN;
        warm_cnt_next = '0;
      end
    endcase
  end

  assign edge_en = (state == RUN);

  // Bits written as 1 to EDGECAP are cleared, unless a new edge arrives
  always_comb begin
    clear_bits = '0;
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      clear_bits = wdata;
    end
  end

  // Interrupt mask and edge-capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
        irq_mask <= wdata;
      end
      edge_cap <= (edge_cap & ~clear_bits) | edges;
    end
  end

  // Zero-wait-state read mux; reserved address and upper bits read 0
  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = sync;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_system_switches_in.sv
// Bench for the Avalon input port: three instances (rising, falling, any
// edge) share one bus and input; directed table, hand-written corner
// sequences and randomized traffic checked against a history-based model.
module tb_nios_system_switches_in;

  localparam int S = 2;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [7:0]       in_port;
  logic [2:0][31:0] rd;
  logic [2:0]       irq_v;

  int n_vec;
  int n_err;

  nios_system_switches_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_port), .irq(irq_v[0]));

  nios_system_switches_in #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_port), .irq(irq_v[1]));

  nios_system_switches_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_port), .irq(irq_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in_val;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_r;
    logic [7:0] exp_f;
    logic [7:0] exp_a;
    logic [2:0] exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Reference model: input history sampled at each clock edge since release
  logic [7:0] hist[$];
  int         n_edges;
  logic [7:0] m_mask [3];
  logic [7:0] m_cap  [3];

  function automatic logic [7:0] sample_at(int j);
    if (j < 1 || j > hist.size()) return 8'h00;
    return hist[j-1];
  endfunction

  function automatic logic [7:0] edge_fn(int t, logic [7:0] cur, logic [7:0] prev);
    if (t == 0) return cur & ~prev;
    if (t == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges = 0;
    for (int t = 0; t < 3; t++) begin
      m_mask[t] = 8'h00;
      m_cap[t]  = 8'h00;
    end
  endtask

  task automatic model_edge(input logic [7:0] in_v, input logic wr,
                            input logic [1:0] addr, input logic [7:0] wd);
    logic [7:0] cur;
    logic [7:0] prev;
    logic [7:0] ev;
    logic [7:0] clr;
    n_edges++;
    hist.push_back(in_v);
    cur  = sample_at(n_edges - S);
    prev = sample_at(n_edges - S - 1);
    clr  = (wr && addr == 2'd3) ? wd : 8'h00;
    for (int t = 0; t < 3; t++) begin
      ev = (n_edges >= S + 2) ? edge_fn(t, cur, prev) : 8'h00;
      m_cap[t] = (m_cap[t] & ~clr) | ev;
      if (wr && addr == 2'd2) m_mask[t] = wd;
    end
  endtask

  function automatic logic [31:0] model_read(int t, logic [1:0] addr);
    case (addr)
      2'd0:    return {24'h0, sample_at(n_edges - S + 1)};
      2'd2:    return {24'h0, m_mask[t]};
      2'd3:    return {24'h0, m_cap[t]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] in_v, input logic wr,
                                input logic [1:0] addr, input logic [31:0] wd);
    in_port    = in_v;
    chipselect = 1'b1;
    write_n    = ~wr;
    address    = addr;
    writedata  = wd;
  endtask

  task automatic do_reset(input logic [7:0] in_v);
    apply_stimulus(in_v, 1'b0, 2'd3, 32'h0);
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic add_row(input logic [7:0] i, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] er, input logic [7:0] ef,
                         input logic [7:0] ea, input logic [2:0] eq);
    vec_t v;
    v.in_val = i; v.wr = w; v.addr = a; v.wdata = d;
    v.exp_r = er; v.exp_f = ef; v.exp_a = ea; v.exp_irq = eq;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    in_port    = 8'h00;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    model_reset();

    // Directed table: one row per clock edge, checked just after the edge
    add_row(8'h00, 1, 2'd2, 8'h05, 8'h05, 8'h05, 8'h05, 3'b000);
    add_row(8'h01, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h01, 0, 2'd0, 8'h00, 8'h01, 8'h01, 8'h01, 3'b000);
    add_row(8'h01, 0, 2'd3, 8'h00, 8'h01, 8'h00, 8'h01, 3'b101);
    add_row(8'h01, 1, 2'd3, 8'h01, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h02, 8'h00, 8'h02, 3'b000);
    add_row(8'h03, 1, 2'd2, 8'h02, 8'h02, 8'h02, 8'h02, 3'b101);
    add_row(8'h03, 1, 2'd3, 8'h02, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h83, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h83, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h83, 0, 2'd3, 8'h00, 8'h80, 8'h00, 8'h80, 3'b000);
    add_row(8'h83, 1, 2'd3, 8'h80, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h80, 8'h80, 3'b000);
    add_row(8'h03, 1, 2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 1, 2'd0, 8'hFF, 8'h03, 8'h03, 8'h03, 3'b000);
    add_row(8'h03, 1, 2'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h03, 0, 2'd2, 8'h00, 8'h02, 8'h02, 8'h02, 3'b000);
    add_row(8'h03, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h07, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h07, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    add_row(8'h07, 1, 2'd3, 8'h04, 8'h04, 8'h00, 8'h04, 3'b000);
    add_row(8'h07, 1, 2'd2, 8'h04, 8'h04, 8'h04, 8'h04, 3'b101);
    add_row(8'h07, 1, 2'd3, 8'h04, 8'h00, 8'h00, 8'h00, 3'b000);

    // Reset with all inputs high: no spurious edges while the chain fills
    do_reset(8'hFF);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step();
      address = 2'd0;
      #1;
      for (int t = 0; t < 3; t++)
        check_output($sformatf("warmup c%0d data[%0d]", c, t), rd[t],
                     (c >= 2) ? 32'hFF : 32'h0);
      address = 2'd3;
      #1;
      for (int t = 0; t < 3; t++) begin
        check_output($sformatf("warmup c%0d edgecap[%0d]", c, t), rd[t], 32'h0);
        check_output($sformatf("warmup c%0d irq[%0d]", c, t), {31'h0, irq_v[t]}, 32'h0);
      end
    end

    // Directed table from a quiet, fully warmed-up state
    do_reset(8'h00);
    repeat (10) step();
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].in_val, vecs[i].wr, vecs[i].addr, {24'h0, vecs[i].wdata});
      step();
      check_output($sformatf("row%0d rd_rise", i), rd[0], {24'h0, vecs[i].exp_r});
      check_output($sformatf("row%0d rd_fall", i), rd[1], {24'h0, vecs[i].exp_f});
      check_output($sformatf("row%0d rd_any", i),  rd[2], {24'h0, vecs[i].exp_a});
      for (int t = 0; t < 3; t++)
        check_output($sformatf("row%0d irq[%0d]", i, t), {31'h0, irq_v[t]},
                     {31'h0, vecs[i].exp_irq[t]});
    end

    // Fill EDGECAP with all ones, then pull reset between clock edges
    apply_stimulus(8'h00, 1'b0, 2'd3, 32'h0);
    repeat (4) step();
    apply_stimulus(8'hFF, 1'b1, 2'd2, 32'hFF);
    step();
    apply_stimulus(8'hFF, 1'b0, 2'd3, 32'h0);
    repeat (4) step();
    check_output("pre-reset edgecap_rise", rd[0], 32'hFF);
    check_output("pre-reset irq_rise", {31'h0, irq_v[0]}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int t = 0; t < 3; t++) begin
      check_output($sformatf("async reset edgecap[%0d]", t), rd[t], 32'h0);
      check_output($sformatf("async reset irq[%0d]", t), {31'h0, irq_v[t]}, 32'h0);
    end

    // Randomized traffic against the history model, several reset rounds
    for (int round = 0; round < 3; round++) begin
      logic [7:0]  in_v;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wd;
      in_v = 8'($urandom());
      do_reset(in_v);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 3) == 0) in_v = 8'($urandom());
        wr   = ($urandom_range(0, 3) == 0);
        addr = 2'($urandom_range(0, 3));
        wd   = $urandom();
        apply_stimulus(in_v, wr, addr, wd);
        step();
        model_edge(in_v, wr, addr, wd[7:0]);
        for (int t = 0; t < 3; t++) begin
          check_output($sformatf("rand r%0d c%0d rd[%0d]", round, c, t), rd[t],
                       model_read(t, addr));
          check_output($sformatf("rand r%0d c%0d irq[%0d]", round, c, t),
                       {31'h0, irq_v[t]}, {31'h0, |(m_cap[t] & m_mask[t])});
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_system_switches_in.md
# nios_system_switches_in

Avalon-MM slave input port: samples an external `WIDTH`-bit input bus (switches, sensor threshold flags) into the `clk` domain, latches per-bit edge events and raises a maskable level interrupt to the Nios II. It is the read-side counterpart of the system's LED output ports. It sits on the same Avalon interconnect with the same zero-wait-state register access.

## Interface
- `WIDTH`, 8: input bus width, 1..32
- `EDGE_TYPE`, 0: edge to capture; 0 = rising, 1 = falling, 2 = any
- `SYNC_STAGES`, 2: synchronizer flops per bit, 2..4
- `clk` in 1: system clock; single clock domain
- `reset_n` in 1: reset, asynchronous and active-low
- `address` in 2: register word select
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe
- `writedata` in 32: write data
- `readdata` out 32: read data, combinational from address
- `in_port` in `WIDTH`: asynchronous external inputs
- `irq` out 1: level interrupt, active-high

## Operation
- Register map:
  - addr 0, DATA (RO): synchronized input.
  - addr 1: reserved, reads 0.
  - addr 2, IRQMASK (RW).
  - addr 3, EDGECAP (R/W1C).
- Unused upper `readdata` bits are always 0. Writes to addr 0/1 are ignored.
- Write condition: `chipselect && !write_n`. Only `writedata[WIDTH-1:0]` is used.
- Synchronizer: `SYNC_STAGES` flops per bit produce `sync`. A further flop produces `sync_d`.
- Edge detect per bit:
  - rising: `sync & ~sync_d`
  - falling: `~sync & sync_d`
  - any: `sync ^ sync_d`
- EDGECAP bit sets on a detected edge and stays set until cleared by a write of 1 to that bit at addr 3. Writing 0 leaves the bit unchanged.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins.
- IRQMASK loads `writedata[WIDTH-1:0]` on a write to addr 2.
- `irq = |(EDGECAP & IRQMASK)`, combinational from registers.
- Warm-up counter: after reset deassertion, edge detection is suppressed for `SYNC_STAGES+1` cycles. This prevents a spurious edge from an input already high (or low) at reset release.
  - Counter states: WARMUP (count down), RUN.
  - The counter reloads on any reset assertion.
- Reset values: sync chain, `sync_d`, IRQMASK, EDGECAP and `irq` are all 0. `readdata` follows the registers, so DATA reads 0 until the chain fills.
- Reset asserted mid-operation clears all state immediately (asynchronous), including pending EDGECAP bits.

## Timing
- Read: zero wait states. `readdata` is valid in the same cycle as `address` and `chipselect`.
- Input to DATA: a change stable before clock edge k is visible at addr 0 after edge k+`SYNC_STAGES`-1, i.e. 2 edges for the default.
- Input to EDGECAP/`irq`: the bit sets at edge k+`SYNC_STAGES`, i.e. 3 edges for the default. `irq` rises in the same cycle if the bit is unmasked.
- W1C write at edge m: the bit reads 0 after edge m, and `irq` deasserts after edge m (unless the set-wins rule applies).
- IRQMASK write at edge m: `irq` reflects the new mask after edge m.
- Pulses shorter than one `clk` period may be missed; no requirement on them.

## Structure
- Package `nios_system_pio_pkg`:
  - register address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3
  - edge-type constants `EDGE_RISING`, `EDGE_FALLING`, `EDGE_ANY`
- Sub-module `nios_system_pio_sync_edge`: parameterized `WIDTH`-bit synchronizer plus delay flop and edge detector. It outputs `sync` and `edge`, with `edge` gated by a warm-up enable input.
- Top level holds the warm-up counter, IRQMASK, EDGECAP, read mux and `irq`.

## Test plan
- Reset with `in_port`=8'hFF held, then release → no EDGECAP bits set and `irq`=0 for 20 cycles. DATA reads 8'hFF from the 3rd cycle after release.
- Defaults (rising edge): set IRQMASK=8'h05, drive `in_port` 8'h00→8'h01 → EDGECAP=8'h01 at the 3rd edge and `irq`=1. Write 8'h01 to addr 3 → EDGECAP=0, `irq`=0.
- Drive `in_port` 8'h00→8'h02 with IRQMASK=8'h05 → EDGECAP=8'h02 and `irq` stays 0. Then write IRQMASK=8'h02 → `irq`=1 on the next cycle.
- Schedule the W1C write of 8'h04 on the same edge that bit 2 captures a new rising edge → EDGECAP bit 2 stays 1.
- `EDGE_TYPE`=2: toggle bit 7 high then low, clearing between the toggles → EDGECAP[7] sets on both transitions. With `EDGE_TYPE`=1, only the high→low transition sets it.
- Reads of addr 1 and writes to addr 0 → readdata=32'h0, and DATA/IRQMASK/EDGECAP are unchanged. Assert `reset_n` low mid-run with EDGECAP=8'hFF → EDGECAP=0 and `irq`=0 immediately, before the next clock edge.
